xilinx_hdl_dpram_pipe: RTL and testbench

Single-clock true dual-port byte-write block RAM with per-port selectable write mode, configurable read latency, valid-tagged read data, same-address collision detection, and an optional hardware memory clear after reset. Intended as the general-purpose on-chip buffer for packet buffers, descriptor tables and AXI-side scratch storage, where consumers need a `vld` strobe and deterministic collision behaviour.

---
 rtl/xilinx_hdl_dpram_pipe_pkg.sv | 21 ++
 rtl/xilinx_hdl_dpram_pipe_if.sv | 35 +++
 rtl/xilinx_hdl_dpram_pipe_rd_pipe.sv | 48 ++++
 rtl/xilinx_hdl_dpram_pipe.sv | 182 ++++++++++++++++++
 tb/tb_xilinx_hdl_dpram_pipe.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xilinx_hdl_dpram_pipe_pkg.sv
// Shared types and limits for the pipelined true dual-port byte-write RAM.
package xilinx_hdl_dpram_pkg;

   typedef enum logic [1:0] {
      WRITE_FIRST = 2'd0,
      READ_FIRST  = 2'd1,
      NO_CHANGE   = 2'd2
   } dpram_wmode_e;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } dpram_state_e;

   localparam int DPRAM_MAX_LATENCY = 4;

   function automatic bit latency_ok(input int lat);
      return (lat >= 1) && (lat <= DPRAM_MAX_LATENCY);
   endfunction

endpackage

// File: rtl/xilinx_hdl_dpram_pipe_if.sv
// Request/response bundle for both RAM ports plus the status strobes.
interface xilinx_hdl_dpram_pipe_if #(
   parameter int NB_COL    = 4,
   parameter int COL_WIDTH = 8,
   parameter int AW        = 10
);
   localparam int DW = NB_COL * COL_WIDTH;

   logic              ena;
   logic [NB_COL-1:0] wea;
   logic [AW-1:0]     addra;
   logic [DW-1:0]     dina;
   logic [DW-1:0]     douta;
   logic              douta_vld;

   logic              enb;
   logic [NB_COL-1:0] web;
   logic [AW-1:0]     addrb;
   logic [DW-1:0]     dinb;
   logic [DW-1:0]     doutb;
   logic              doutb_vld;

   logic              collision;
   logic              init_busy;

   modport master (
      output ena, wea, addra, dina, enb, web, addrb, dinb,
      input  douta, douta_vld, doutb, doutb_vld, collision, init_busy
   );

   modport slave (
      input  ena, wea, addra, dina, enb, web, addrb, dinb,
      output douta, douta_vld, doutb, doutb_vld, collision, init_busy
   );
endinterface

// File: rtl/xilinx_hdl_dpram_pipe_rd_pipe.sv
// Read-data delay line with a valid tag; each stage keeps the last valid word it saw.
module dpram_rd_pipe #(
   parameter int DW     = 32,
   parameter int STAGES = 1
) (
   input  logic          clka,
   input  logic          rstb,
   input  logic [DW-1:0] i_data,
   input  logic          i_vld,
   output logic [DW-1:0] o_data,
   output logic          o_vld
);

   generate
      if (STAGES == 0) begin : g_bypass
         assign o_data = i_data;
         assign o_vld  = i_vld;
      end else begin : g_delay
         logic [DW-1:0]     r_data [STAGES];
         logic [STAGES-1:0] r_vld;

         // Data only advances alongside its valid tag, so the output holds when vld is low
         always_ff @(posedge clka) begin
            if (rstb) begin
               for (int i = 0; i < STAGES; i++) begin
                  r_data[i] <= '0;
               end
               r_vld <= '0;
            end else begin
               r_vld[0] <= i_vld;
               if (i_vld) begin
                  r_data[0] <= i_data;
               end
               for (int i = 1; i < STAGES; i++) begin
                  r_vld[i] <= r_vld[i-1];
                  if (r_vld[i-1]) begin
                     r_data[i] <= r_data[i-1];
                  end
               end
            end
         end

         assign o_data = r_data[STAGES-1];
         assign o_vld  = r_vld[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/xilinx_hdl_dpram_pipe.sv
// True dual-port byte-write RAM with per-port write mode, pipelined valid-tagged
// reads, same-address collision flag and an optional post-reset memory clear.
module xilinx_hdl_dpram_pipe
   import xilinx_hdl_dpram_pkg::*;
#(
   parameter int           NB_COL         = 4,
   parameter int           COL_WIDTH      = 8,
   parameter int           RAM_DEPTH      = 1024,
   parameter int           READ_LATENCY   = 2,
   parameter dpram_wmode_e WRITE_MODE_A   = WRITE_FIRST,
   parameter dpram_wmode_e WRITE_MODE_B   = WRITE_FIRST,
   parameter int           CLEAR_ON_RESET = 1
) (
   input logic                    clka,
   input logic                    rstb,
   xilinx_hdl_dpram_pipe_if.slave bus
);

   localparam int AW = $clog2(RAM_DEPTH);
   localparam int DW = NB_COL * COL_WIDTH;

   generate
      if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
         $error("READ_LATENCY must be in 1..%0d", DPRAM_MAX_LATENCY);
      end
   endgenerate

   logic [DW-1:0] r_mem [RAM_DEPTH];

   dpram_state_e  r_state;
   dpram_state_e  w_state_nxt;
   logic [AW-1:0] r_clr_addr;
   logic [AW-1:0] w_clr_addr_nxt;
   logic          r_init_busy;

   logic          w_acc_a, w_acc_b;
   logic [DW-1:0] w_old_a, w_old_b;
   logic [DW-1:0] w_rd_a, w_rd_b;
   logic          w_vld_a, w_vld_b;
   logic          w_coll;

   logic [DW-1:0] r_rd_a, r_rd_b;
   logic          r_vld_a, r_vld_b;
   logic          r_collision;

   logic [DW-1:0] w_pipe_a_data, w_pipe_b_data;
   logic          w_pipe_a_vld, w_pipe_b_vld;

   function automatic logic [DW-1:0] merge_cols(input logic [DW-1:0]     old_word,
                                                input logic [DW-1:0]     new_word,
                                                input logic [NB_COL-1:0] we);
      logic [DW-1:0] res;
      res = old_word;
      for (int i = 0; i < NB_COL; i++) begin
         if (we[i]) begin
            res[i*COL_WIDTH +: COL_WIDTH] = new_word[i*COL_WIDTH +: COL_WIDTH];
         end
      end
      return res;
   endfunction

   function automatic logic [DW-1:0] read_word(input dpram_wmode_e         mode,
                                               input logic [DW-1:0]     old_word,
                                               input logic [DW-1:0]     new_word,
                                               input logic [NB_COL-1:0] we);
      case (mode)
         WRITE_FIRST: return merge_cols(old_word, new_word, we);
         default:     return old_word;
      endcase
   endfunction

   // Clear sequencer next state: sweep every address once, then serve requests
   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      case (r_state)
         CLEAR: begin
            if (r_clr_addr == AW'(RAM_DEPTH - 1)) begin
               w_state_nxt    = RUN;
               w_clr_addr_nxt = '0;
            end else begin
               w_clr_addr_nxt = r_clr_addr + AW'(1);
            end
         end
         RUN: begin
            w_state_nxt = RUN;
         end
         default: begin
            w_state_nxt    = CLEAR;
            w_clr_addr_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clka) begin
      if (rstb) begin
         r_state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
         r_clr_addr  <= '0;
         r_init_busy <= (CLEAR_ON_RESET != 0);
      end else begin
         r_state     <= w_state_nxt;
         r_clr_addr  <= w_clr_addr_nxt;
         r_init_busy <= (w_state_nxt == CLEAR);
      end
   end

   assign w_acc_a = bus.ena && !rstb && (r_state == RUN);
   assign w_acc_b = bus.enb && !rstb && (r_state == RUN);

   // Port A is written last so it wins columns that both ports write
   always_ff @(posedge clka) begin
      if (!rstb && (r_state == CLEAR)) begin
         r_mem[r_clr_addr] <= '0;
      end else begin
         for (int i = 0; i < NB_COL; i++) begin
            if (w_acc_b && bus.web[i]) begin
               r_mem[bus.addrb][i*COL_WIDTH +: COL_WIDTH] <= bus.dinb[i*COL_WIDTH +: COL_WIDTH];
            end
            if (w_acc_a && bus.wea[i]) begin
               r_mem[bus.addra][i*COL_WIDTH +: COL_WIDTH] <= bus.dina[i*COL_WIDTH +: COL_WIDTH];
            end
         end
      end
   end

   always_comb begin
      w_old_a = r_mem[bus.addra];
      w_old_b = r_mem[bus.addrb];
      w_rd_a  = read_word(WRITE_MODE_A, w_old_a, bus.dina, bus.wea);
      w_rd_b  = read_word(WRITE_MODE_B, w_old_b, bus.dinb, bus.web);
      w_vld_a = w_acc_a && !((WRITE_MODE_A == NO_CHANGE) && (|bus.wea));
      w_vld_b = w_acc_b && !((WRITE_MODE_B == NO_CHANGE) && (|bus.web));
      w_coll  = w_acc_a && w_acc_b && (bus.addra == bus.addrb) && ((|bus.wea) || (|bus.web));
   end

   // First read stage; later stages live in the per-port delay lines
   always_ff @(posedge clka) begin
      if (rstb) begin
         r_rd_a      <= '0;
         r_rd_b      <= '0;
         r_vld_a     <= 1'b0;
         r_vld_b     <= 1'b0;
         r_collision <= 1'b0;
      end else begin
         r_vld_a     <= w_vld_a;
         r_vld_b     <= w_vld_b;
         r_collision <= w_coll;
         if (w_vld_a) begin
            r_rd_a <= w_rd_a;
         end
         if (w_vld_b) begin
            r_rd_b <= w_rd_b;
         end
      end
   end

   dpram_rd_pipe #(.DW(DW), .STAGES(READ_LATENCY - 1)) u_pipe_a (
      .clka   (clka),
      .rstb   (rstb),
      .i_data (r_rd_a),
      .i_vld  (r_vld_a),
      .o_data (w_pipe_a_data),
      .o_vld  (w_pipe_a_vld)
   );

   dpram_rd_pipe #(.DW(DW), .STAGES(READ_LATENCY - 1)) u_pipe_b (
      .clka   (clka),
      .rstb   (rstb),
      .i_data (r_rd_b),
      .i_vld  (r_vld_b),
      .o_data (w_pipe_b_data),
      .o_vld  (w_pipe_b_vld)
   );

   assign bus.douta     = w_pipe_a_data;
   assign bus.douta_vld = w_pipe_a_vld;
   assign bus.doutb     = w_pipe_b_data;
   assign bus.doutb_vld = w_pipe_b_vld;
   assign bus.collision = r_collision;
   assign bus.init_busy = r_init_busy;

endmodule

// File: tb/tb_xilinx_hdl_dpram_pipe.sv
// Drives three RAM configurations (latency 2/1/4, mixed write modes) with shared
// stimulus and compares every output each cycle against a word-level reference model.
module tb_xilinx_hdl_dpram_pipe;
   import xilinx_hdl_dpram_pkg::*;

   localparam int DEPTH = 16;
   localparam int NDUT  = 3;

   logic        clk;
   logic        rstb;
   logic        ena, enb;
   logic [3:0]  wea, web;
   logic [3:0]  addra, addrb;
   logic [31:0] dina, dinb;

   xilinx_hdl_dpram_pipe_if #(.NB_COL(4), .COL_WIDTH(8), .AW(4)) if0 ();
   xilinx_hdl_dpram_pipe_if #(.NB_COL(4), .COL_WIDTH(8), .AW(4)) if1 ();
   xilinx_hdl_dpram_pipe_if #(.NB_COL(4), .COL_WIDTH(8), .AW(4)) if2 ();

   assign if0.ena = ena;  assign if0.wea = wea;  assign if0.addra = addra;  assign if0.dina = dina;
   assign if0.enb = enb;  assign if0.web = web;  assign if0.addrb = addrb;  assign if0.dinb = dinb;
   assign if1.ena = ena;  assign if1.wea = wea;  assign if1.addra = addra;  assign if1.dina = dina;
   assign if1.enb = enb;  assign if1.web = web;  assign if1.addrb = addrb;  assign if1.dinb = dinb;
   assign if2.ena = ena;  assign if2.wea = wea;  assign if2.addra = addra;  assign if2.dina = dina;
   assign if2.enb = enb;  assign if2.web = web;  assign if2.addrb = addrb;  assign if2.dinb = dinb;

   xilinx_hdl_dpram_pipe #(
      .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .READ_LATENCY(2),
      .WRITE_MODE_A(WRITE_FIRST), .WRITE_MODE_B(READ_FIRST), .CLEAR_ON_RESET(1)
   ) u_dut0 (.clka(clk), .rstb(rstb), .bus(if0));

   xilinx_hdl_dpram_pipe #(
      .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .READ_LATENCY(1),
      .WRITE_MODE_A(WRITE_FIRST), .WRITE_MODE_B(NO_CHANGE), .CLEAR_ON_RESET(1)
   ) u_dut1 (.clka(clk), .rstb(rstb), .bus(if1));

   xilinx_hdl_dpram_pipe #(
      .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .READ_LATENCY(4),
      .WRITE_MODE_A(READ_FIRST), .WRITE_MODE_B(WRITE_FIRST), .CLEAR_ON_RESET(1)
   ) u_dut2 (.clka(clk), .rstb(rstb), .bus(if2));

   logic [31:0] obs_dout [NDUT][2];
   logic        obs_vld  [NDUT][2];
   logic        obs_coll [NDUT];
   logic        obs_busy [NDUT];

   always_comb begin
      obs_dout[0][0] = if0.douta;  obs_vld[0][0] = if0.douta_vld;
      obs_dout[0][1] = if0.doutb;  obs_vld[0][1] = if0.doutb_vld;
      obs_dout[1][0] = if1.douta;  obs_vld[1][0] = if1.douta_vld;
      obs_dout[1][1] = if1.doutb;  obs_vld[1][1] = if1.doutb_vld;
      obs_dout[2][0] = if2.douta;  obs_vld[2][0] = if2.douta_vld;
      obs_dout[2][1] = if2.doutb;  obs_vld[2][1] = if2.doutb_vld;
      obs_coll[0] = if0.collision; obs_busy[0] = if0.init_busy;
      obs_coll[1] = if1.collision; obs_busy[1] = if1.init_busy;
      obs_coll[2] = if2.collision; obs_busy[2] = if2.init_busy;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] m_mem [DEPTH];
   int          clr_cnt;
   int          cyc;
   logic        s_vld [NDUT][2][8];
   logic [31:0] s_dat [NDUT][2][8];
   logic [31:0] last  [NDUT][2];
   logic        exp_coll;
   logic        exp_busy;

   int n_cmp;
   int n_err;
   int busy_cnt;

   function automatic int lat_of(input int d);
      case (d)
         0:       return 2;
         1:       return 1;
         default: return 4;
      endcase
   endfunction

   function automatic dpram_wmode_e mode_of(input int d, input int p);
      case ({d[1:0], p[0]})
         3'b000:  return WRITE_FIRST;
         3'b001:  return READ_FIRST;
         3'b010:  return WRITE_FIRST;
         3'b011:  return NO_CHANGE;
         3'b100:  return READ_FIRST;
         default: return WRITE_FIRST;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Schedule what one accepted access should return LAT cycles later
   task automatic sched(input int d, input int p, input logic acc, input logic [3:0] we,
                        input logic [31:0] din, input logic [31:0] old_w);
      dpram_wmode_e md;
      logic [31:0]  rd;
      int           sl;
      md = mode_of(d, p);
      sl = (cyc + lat_of(d)) % 8;
      if (acc && !((md == NO_CHANGE) && (we != 4'd0))) begin
         rd = old_w;
         if (md == WRITE_FIRST) begin
            for (int i = 0; i < 4; i++) begin
               if (we[i]) rd[8*i +: 8] = din[8*i +: 8];
            end
         end
         s_vld[d][p][sl] = 1'b1;
         s_dat[d][p][sl] = rd;
      end
   endtask

   task automatic check_outputs();
      int   sl;
      logic ev;
      sl = cyc % 8;
      for (int d = 0; d < NDUT; d++) begin
         for (int p = 0; p < 2; p++) begin
            ev = s_vld[d][p][sl];
            if (ev) last[d][p] = s_dat[d][p][sl];
            s_vld[d][p][sl] = 1'b0;
            chk($sformatf("d%0d_p%0d_vld@%0d", d, p, cyc), {31'd0, obs_vld[d][p]}, {31'd0, ev});
            chk($sformatf("d%0d_p%0d_dout@%0d", d, p, cyc), obs_dout[d][p], last[d][p]);
         end
         chk($sformatf("d%0d_collision@%0d", d, cyc), {31'd0, obs_coll[d]}, {31'd0, exp_coll});
         chk($sformatf("d%0d_init_busy@%0d", d, cyc), {31'd0, obs_busy[d]}, {31'd0, exp_busy});
      end
   endtask

   // One clock: update the model with the presented request, clock, then compare
   task automatic step();
      logic        acc_a, acc_b;
      logic [31:0] old_a, old_b;
      if (rstb) begin
         clr_cnt = 0;
         for (int d = 0; d < NDUT; d++) begin
            for (int p = 0; p < 2; p++) begin
               last[d][p] = 32'd0;
               for (int s = 0; s < 8; s++) s_vld[d][p][s] = 1'b0;
            end
         end
         exp_coll = 1'b0;
         exp_busy = 1'b1;
      end else begin
         acc_a = ena && (clr_cnt >= DEPTH);
         acc_b = enb && (clr_cnt >= DEPTH);
         if (clr_cnt < DEPTH) begin
            m_mem[clr_cnt] = 32'd0;
            clr_cnt++;
         end
         exp_busy = (clr_cnt < DEPTH);
         old_a = m_mem[addra];
         old_b = m_mem[addrb];
         for (int d = 0; d < NDUT; d++) begin
            sched(d, 0, acc_a, wea, dina, old_a);
            sched(d, 1, acc_b, web, dinb, old_b);
         end
         exp_coll = acc_a && acc_b && (addra == addrb) && ((wea != 4'd0) || (web != 4'd0));
         for (int i = 0; i < 4; i++) begin
            if (acc_b && web[i]) m_mem[addrb][8*i +: 8] = dinb[8*i +: 8];
            if (acc_a && wea[i]) m_mem[addra][8*i +: 8] = dina[8*i +: 8];
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                        input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
      ena = ea; wea = wa; addra = aa; dina = da;
      enb = eb; web = wb; addrb = ab; dinb = db;
   endtask

   task automatic drive_random(input int amax);
      ena   = ($urandom_range(0, 3) != 0);
      wea   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0;
      addra = 4'($urandom_range(0, amax));
      dina  = $urandom;
      enb   = ($urandom_range(0, 3) != 0);
      web   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0;
      addrb = 4'($urandom_range(0, amax));
      dinb  = $urandom;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 32'd0);
      repeat (n) step();
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      cyc     = 0;
      clr_cnt = 0;
      rstb    = 1'b1;
      idle(3);

      // Clear after reset: busy for exactly DEPTH cycles, requests meanwhile dropped
      rstb     = 1'b0;
      busy_cnt = 0;
      repeat (20) begin
         if (obs_busy[0] === 1'b1) busy_cnt++;
         drive_random(15);
         step();
      end
      chk("busy_len_first", 32'(busy_cnt), 32'd16);

      // Every address reads back zero on both ports
      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b1, 4'd0, 4'(a), 32'd0, 1'b1, 4'd0, 4'(15 - a), 32'd0);
         step();
      end
      idle(5);

      // Partial write-first over 0x11223344, then port B reads it next cycle
      drive(1'b1, 4'hF, 4'd5, 32'h11223344, 1'b0, 4'd0, 4'd0, 32'd0);
      step();
      drive(1'b1, 4'b0011, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 4'd0, 32'd0);
      step();
      drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd0, 4'd5, 32'd0);
      step();
      idle(5);

      // Port B full write over a zero word: read-first / no-change / write-first
      drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'hF, 4'd7, 32'hAAAAAAAA);
      step();
      idle(5);

      // Same-address write collision, then read the merged word back
      drive(1'b1, 4'b0001, 4'd3, 32'h000000FF, 1'b1, 4'b1101, 4'd3, 32'hFFFF0000);
      step();
      drive(1'b1, 4'd0, 4'd3, 32'd0, 1'b1, 4'd0, 4'd3, 32'd0);
      step();
      idle(5);

      // Dual reads of one address are not a collision
      drive(1'b1, 4'd0, 4'd9, 32'd0, 1'b1, 4'd0, 4'd9, 32'd0);
      step();
      idle(5);

      // Random traffic, narrow address range to provoke collisions
      repeat (300) begin
         drive_random(3);
         step();
      end
      repeat (200) begin
         drive_random(15);
         step();
      end
      idle(5);

      // Reset while the clear is at address 9, then the clear restarts
      rstb = 1'b1;
      idle(1);
      rstb = 1'b0;
      repeat (9) begin
         drive_random(15);
         step();
      end
      rstb = 1'b1;
      drive_random(15);
      step();
      rstb     = 1'b0;
      busy_cnt = 0;
      repeat (20) begin
         if (obs_busy[0] === 1'b1) busy_cnt++;
         drive_random(15);
         step();
      end
      chk("busy_len_restart", 32'(busy_cnt), 32'd16);

      // Latency sweep: fill 0..7, then back-to-back reads on both ports
      for (int a = 0; a < 8; a++) begin
         drive(1'b1, 4'hF, 4'(a), $urandom, 1'b0, 4'd0, 4'd0, 32'd0);
         step();
      end
      for (int a = 0; a < 8; a++) begin
         drive(1'b1, 4'd0, 4'(a), 32'd0, 1'b1, 4'd0, 4'(7 - a), 32'd0);
         step();
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
